// File: rtl/reg_file_bank.sv
// reg_file_bank: byte register file with registered read port and REG0..REG3 export.
// Optional RF_RD_WR_SAME_CYCLE_EN: a colliding read returns the write data.
module reg_file_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              WrEn,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              RdData_Valid,
  output logic [DATA_W-1:0] REG0,
  output logic [DATA_W-1:0] REG1,
  output logic [DATA_W-1:0] REG2,
  output logic [DATA_W-1:0] REG3
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              rd_go;
  logic [DATA_W-1:0] rd_val;

  assign in_range = (32'(Address) < DEPTH);
  assign idx      = Address[IDX_W-1:0];

  // One flop bank per register so each carries its own reset value.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL =
      (g == 2) ? DATA_W'(8'h81) :
      (g == 3) ? DATA_W'(8'h20) : '0;

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        regs[g] <= RST_VAL;
      end else if (WrEn && in_range && (32'(idx) == g)) begin
        regs[g] <= WrData;
      end
    end
  end

`ifdef RF_RD_WR_SAME_CYCLE_EN
  assign rd_go = RdEn;

  always_comb begin
    rd_val = '0;
    if (in_range) begin
      rd_val = WrEn ? WrData : regs[idx];
    end
  end
`else
  // A colliding write wins; the read is dropped.
  assign rd_go = RdEn && !WrEn;

  always_comb begin
    rd_val = '0;
    if (in_range) begin
      rd_val = regs[idx];
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      RdData       <= '0;
      RdData_Valid <= 1'b0;
    end else begin
      RdData_Valid <= rd_go;
      if (rd_go) begin
        RdData <= rd_val;
      end
    end
  end

  assign REG0 = regs[0];
  assign REG1 = regs[1];
  assign REG2 = regs[2];
  assign REG3 = regs[3];

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: directed stimulus, expected read data queued and
// checked by an independent monitor on each RdData_Valid cycle.
module tb_reg_file_bank;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 8;

  logic          CLK;
  logic          RST_n;
  logic          WrEn;
  logic          RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic          RdData_Valid;
  logic [DW-1:0] REG0, REG1, REG2, REG3;

  int tests;
  int fails;
  logic [DW-1:0] exq [$];

  reg_file_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .Address(Address),
    .WrData(WrData),
    .RdData(RdData),
    .RdData_Valid(RdData_Valid),
    .REG0(REG0),
    .REG1(REG1),
    .REG2(REG2),
    .REG3(REG3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic idle();
    WrEn = 1'b0;
    RdEn = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WrEn    = 1'b1;
    RdEn    = 1'b0;
    Address = a;
    WrData  = d;
    @(posedge CLK);
    #1;
    WrEn = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    WrEn    = 1'b0;
    RdEn    = 1'b1;
    Address = a;
    exq.push_back(e);
    @(posedge CLK);
    #1;
    RdEn = 1'b0;
  endtask

  // Monitor: every valid cycle must match the next queued expectation.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge CLK);
      if (RdData_Valid === 1'b1) begin
        tests++;
        if (exq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: got %02h want no valid", RdData);
        end else begin
          e = exq.pop_front();
          if (RdData !== e) begin
            fails++;
            $display("FAIL rd_data: got %02h want %02h", RdData, e);
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] rv;
    tests   = 0;
    fails   = 0;
    RST_n   = 1'b0;
    WrEn    = 1'b0;
    RdEn    = 1'b0;
    Address = '0;
    WrData  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_reg0", REG0, 8'h00);
    chk("rst_reg1", REG1, 8'h00);
    chk("rst_reg2", REG2, 8'h81);
    chk("rst_reg3", REG3, 8'h20);
    chk("rst_rddata", RdData, 8'h00);
    chk("rst_valid", {7'd0, RdData_Valid}, 8'h00);
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK);
    #1;

    for (int a = 0; a < 16; a++) begin
      rv = (a == 2) ? 8'h81 : (a == 3) ? 8'h20 : 8'h00;
      rd(AW'(a), rv);
    end
    idle();

    wr(4'd5, 8'hA7);
    rd(4'd5, 8'hA7);
    idle();

    wr(4'd0, 8'h12);
    chk("export_reg0", REG0, 8'h12);
    wr(4'd1, 8'h34);
    chk("export_reg1", REG1, 8'h34);
    chk("export_reg0_hold", REG0, 8'h12);
    idle();

    rd(4'd2, 8'h81);
    rd(4'd3, 8'h20);
    rd(4'd0, 8'h12);
    idle();
    idle();

    WrEn    = 1'b1;
    RdEn    = 1'b1;
    Address = 4'd7;
    WrData  = 8'h5C;
`ifdef RF_RD_WR_SAME_CYCLE_EN
    exq.push_back(8'h5C);
`endif
    @(posedge CLK);
    #1;
    WrEn = 1'b0;
    RdEn = 1'b0;
    idle();
    rd(4'd7, 8'h5C);
    idle();

    wr(4'd9, 8'hFF);
    chk("oor_reg0", REG0, 8'h12);
    chk("oor_reg1", REG1, 8'h34);
    chk("oor_reg2", REG2, 8'h81);
    chk("oor_reg3", REG3, 8'h20);
    rd(4'd1, 8'h34);
    rd(4'd9, 8'h00);
    rd(4'd15, 8'h00);
    idle();
    idle();

    RdEn    = 1'b1;
    Address = 4'd2;
    #2;
    RST_n = 1'b0;
    @(posedge CLK);
    #1;
    RdEn = 1'b0;
    chk("mid_rst_reg0", REG0, 8'h00);
    chk("mid_rst_reg1", REG1, 8'h00);
    chk("mid_rst_reg2", REG2, 8'h81);
    chk("mid_rst_reg3", REG3, 8'h20);
    chk("mid_rst_rddata", RdData, 8'h00);
    chk("mid_rst_valid", {7'd0, RdData_Valid}, 8'h00);
    @(negedge CLK);
    RST_n = 1'b1;
    idle();
    idle();
    chk("post_rst_valid", {7'd0, RdData_Valid}, 8'h00);
    rd(4'd5, 8'h00);
    rd(4'd7, 8'h00);
    idle();
    idle();

    tests++;
    if (exq.size() != 0) begin
      fails++;
      $display("FAIL pending_reads: got %0d outstanding want 0", exq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
